// File: rtl/mem_bus_master.sv
// Single-line memory bus master: reads or writes one cache line over a shared,
// tri-stated command/data bus, measuring the latency to the first response.
module mem_bus_master #(
    parameter int         ADDR_W        = 16,
    parameter int         DATA_W        = 16,
    parameter int         LINE_BYTES    = 16,
    parameter logic [1:0] C2_NOP        = 2'd0,
    parameter logic [1:0] C2_RESPONSE   = 2'd1,
    parameter logic [1:0] C2_READ_LINE  = 2'd2,
    parameter logic [1:0] C2_WRITE_LINE = 2'd3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LINE_BYTES*8-1:0] req_wdata,
    output logic                    req_ready,
    output logic                    resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_rdata,
    output logic [15:0]             last_latency,
    output logic [ADDR_W-1:0]       addr_w,
    inout  wire  [DATA_W-1:0]       data_w,
    inout  wire  [1:0]              cmd_w
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_WAIT, WR_DATA, WR_WAIT, DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rd_buf;
    logic [LINE_W-1:0]   r_rdata;
    logic [LINE_W-1:0]   w_rd_next;
    logic [BEAT_W-1:0]   r_beat;
    logic [15:0]         r_lat;
    logic [15:0]         r_last_lat;
    logic                r_lat_run;
    logic                w_own;
    logic [1:0]          w_cmd_out;
    logic [DATA_W-1:0]   w_data_out;
    logic                w_rsp;
    logic                w_accept;
    logic                w_waiting;
    logic                w_last_beat;

    // An X/Z command compares unknown, and unknown conditions fall to the not-taken branch.
    assign w_rsp       = (cmd_w == C2_RESPONSE);
    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_waiting   = (r_state == RD_WAIT) || (r_state == WR_WAIT);
    assign w_last_beat = (r_beat == LAST_BEAT);

    assign cmd_w        = w_own ? w_cmd_out : 'z;
    assign data_w       = w_own ? w_data_out : 'z;
    assign addr_w       = r_addr;
    assign resp_rdata   = r_rdata;
    assign last_latency = r_last_lat;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = req_write ? WR_DATA : RD_CMD;
            RD_CMD:  w_next = RD_WAIT;
            RD_WAIT: if (w_rsp && w_last_beat) w_next = DONE;
            WR_DATA: if (w_last_beat) w_next = WR_WAIT;
            WR_WAIT: if (w_rsp) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_own      = 1'b1;
        w_cmd_out  = C2_NOP;
        w_data_out = '0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            RD_CMD:  w_cmd_out = C2_READ_LINE;
            RD_WAIT: w_own = 1'b0;
            WR_DATA: begin
                w_cmd_out  = C2_WRITE_LINE;
                w_data_out = r_wdata[r_beat*DATA_W +: DATA_W];
            end
            WR_WAIT: w_own = 1'b0;
            DONE:    resp_valid = 1'b1;
            default: w_own = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_buf;
        w_rd_next[r_beat*DATA_W +: DATA_W] = data_w;
    end

    // NOTE: the line buffers are plain registers, so they are cleared by reset like any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_buf   <= '0;
            r_rdata    <= '0;
            r_beat     <= '0;
            r_lat      <= '0;
            r_last_lat <= '0;
            r_lat_run  <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_beat    <= '0;
            r_lat     <= '0;
            r_lat_run <= 1'b1;
        end else begin
            if (r_lat_run) begin
                if (w_waiting && w_rsp) begin
                    r_last_lat <= r_lat;
                    r_lat_run  <= 1'b0;
                end else if (r_lat != 16'hFFFF) begin
                    r_lat <= r_lat + 16'd1;
                end
            end
            case (r_state)
                WR_DATA: r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                RD_WAIT: begin
                    if (w_rsp) begin
                        r_rd_buf <= w_rd_next;
                        r_beat   <= w_last_beat ? '0 : r_beat + 1'b1;
                        if (w_last_beat) r_rdata <= w_rd_next;
                    end
                end
                default: r_beat <= r_beat;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a behavioural bus responder backed by a line memory,
// a transaction-level model of completions, and directed line transfers.
module tb_mem_bus_master;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LINE_W = 128;
    localparam int BEATS  = 8;
    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_rdata;
    logic [15:0]       last_latency;
    logic [ADDR_W-1:0] addr_w;
    wire  [DATA_W-1:0] data_w;
    wire  [1:0]        cmd_w;

    logic              rsp_oe = 1'b0;
    logic [1:0]        rsp_cmd = C2_NOP;
    logic [DATA_W-1:0] rsp_data = '0;
    assign cmd_w  = rsp_oe ? rsp_cmd : 'z;
    assign data_w = rsp_oe ? rsp_data : 'z;

    mem_bus_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .last_latency(last_latency),
        .addr_w(addr_w), .data_w(data_w), .cmd_w(cmd_w)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural line memory shared by the responder and the model.
    logic [LINE_W-1:0] mem [16];
    logic [DATA_W-1:0] wr_beats [BEATS];
    int rsp_lat = 10;
    int rsp_gap = 0;
    logic rsp_abort;

    task automatic rsp_step();
        @(posedge clk); #2;
        if (reset) rsp_abort = 1'b1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [DATA_W-1:0] d);
        rsp_oe = 1'b1; rsp_cmd = c; rsp_data = d;
    endtask

    initial begin : responder
        logic [LINE_W-1:0] line;
        int a;
        forever begin
            rsp_abort = 1'b0;
            rsp_step();
            if (!rsp_abort && cmd_w === C2_READ_LINE) begin
                a = int'(addr_w[3:0]);
                line = mem[a];
                for (int i = 0; i < rsp_lat && !rsp_abort; i++) rsp_step();
                if (!rsp_abort) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (b > 0) begin
                            for (int g = 0; g < rsp_gap; g++) begin
                                rsp_step();
                                drive(C2_NOP, '0);
                            end
                            rsp_step();
                        end
                        drive(C2_RESPONSE, line[b*DATA_W +: DATA_W]);
                    end
                    rsp_step();
                end
                rsp_oe = 1'b0;
            end else if (!rsp_abort && cmd_w === C2_WRITE_LINE) begin
                a = int'(addr_w[3:0]);
                for (int k = 0; k < BEATS; k++) begin
                    if (k > 0) begin
                        rsp_step();
                        check("wr_cmd_beat", cmd_w, C2_WRITE_LINE);
                    end
                    wr_beats[k] = data_w;
                    line[k*DATA_W +: DATA_W] = data_w;
                end
                rsp_step();
                check("wr_cmd_len", cmd_w === C2_WRITE_LINE, 1'b0);
                for (int i = BEATS; i < rsp_lat && !rsp_abort; i++) rsp_step();
                if (!rsp_abort) begin
                    drive(C2_RESPONSE, '0);
                    mem[a] = line;
                    rsp_step();
                end
                rsp_oe = 1'b0;
            end
        end
    end

    // Transaction-level model: outstanding requests, last read line, current address.
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                lat;
    } txn_t;

    txn_t              q[$];
    logic [LINE_W-1:0] m_rdata = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    int n_resp = 0;
    int n_accept = 0;

    always @(negedge clk) begin : compare
        txn_t t;
        if (reset) begin
            q.delete();
            m_rdata = '0;
            m_addr  = '0;
        end else begin
            check("ready", req_ready, q.size() == 0);
            check("addr_w", addr_w, m_addr);
            if (req_ready) begin
                check("idle_cmd", cmd_w, C2_NOP);
                check("idle_data", data_w, '0);
            end
            if (resp_valid) begin
                n_resp++;
                check("resp_pending", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    t = q.pop_front();
                    check("done_cmd", cmd_w, C2_NOP);
                    if (!t.wr) m_rdata = mem[t.addr[3:0]];
                    check("latency", last_latency, t.lat);
                end
            end
            check("rdata", resp_rdata, m_rdata);
            if (req_ready && req_valid) begin
                q.push_back('{wr: req_write, addr: req_addr, wdata: req_wdata, lat: rsp_lat});
                m_addr = req_addr;
                n_accept++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_accept();
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
        end
        check("accept", acc, 1'b1);
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
    endtask

    // Leaves the caller at the negedge of the completion cycle.
    task automatic wait_resp(input int max_cycles);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        check("resp_seen", got, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p;
        int a0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < BEATS; b++)
                mem[i][b*DATA_W +: DATA_W] = 16'((i << 8) | b);
        mem[0] = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        mem[7] = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, '0);
        check("rst_latency", last_latency, '0);
        check("rst_addr", addr_w, '0);
        check("rst_cmd", cmd_w, C2_NOP);
        check("rst_data", data_w, '0);
        tick();

        // Read of line 0 answered 100 cycles after issue.
        rsp_lat = 100; rsp_gap = 0;
        p = n_resp;
        issue(1'b0, 16'd0, '0);
        wait_resp(300);
        check("rd0_rdata", resp_rdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("rd0_latency", last_latency, 16'd100);
        repeat (5) tick();
        check("rd0_pulses", n_resp - p, 1);

        // Write of a small payload to line 5.
        rsp_lat = 12;
        issue(1'b1, 16'd5, 128'h10101);
        wait_resp(100);
        check("wr5_latency", last_latency, 16'd12);
        check("wr5_rdata_held", resp_rdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("wr5_beat0", wr_beats[0], 16'h0101);
        check("wr5_beat1", wr_beats[1], 16'h0001);
        for (int k = 2; k < BEATS; k++) check("wr5_beat_hi", wr_beats[k], 16'h0000);
        tick();

        // Read back line 5.
        rsp_lat = 20;
        issue(1'b0, 16'd5, '0);
        wait_resp(100);
        check("rd5_rdata", resp_rdata, 128'h10101);
        check("rd5_latency", last_latency, 16'd20);
        tick();

        // Two NOP gaps between beats.
        rsp_lat = 5; rsp_gap = 2;
        p = n_resp;
        issue(1'b0, 16'd7, '0);
        wait_resp(100);
        check("gap_rdata", resp_rdata, 128'h7777_6666_5555_4444_3333_2222_1111_0000);
        repeat (5) tick();
        check("gap_pulses", n_resp - p, 1);
        rsp_gap = 0;

        // Reset while waiting for read data.
        rsp_lat = 60;
        issue(1'b0, 16'd3, '0);
        repeat (20) tick();
        p = n_resp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_cmd", cmd_w, C2_NOP);
        check("abort_ready", req_ready, 1'b1);
        check("abort_rdata", resp_rdata, '0);
        repeat (80) tick();
        check("abort_no_resp", n_resp - p, 0);

        // Request held high across a busy write; the read behind it starts after DONE.
        rsp_lat = 10;
        p = n_resp;
        req_write = 1'b1; req_addr = 16'd9;
        req_wdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        req_valid = 1'b1;
        wait_accept();
        a0 = n_accept;
        req_write = 1'b0;
        wait_accept();
        req_valid = 1'b0;
        check("b2b_first_done", n_resp - p, 1);
        check("b2b_accepts", n_accept - a0, 1);
        wait_resp(100);
        check("b2b_rdata", resp_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        repeat (5) tick();
        check("b2b_pulses", n_resp - p, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
